// File: rtl/lane_fill_sched.sv
// Round-robin scheduler that lets NREQ requesters fill one shared WIDTH-bit
// register lane by lane. A driven mask tracks which lanes hold data.
module lane_fill_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 128,
  parameter int LANE  = 8,
  parameter int LW    = $clog2(WIDTH/LANE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*LW-1:0]     req_lane,
  input  logic [NREQ*LANE-1:0]   req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   clear,
  output logic [WIDTH-1:0]       out,
  output logic [WIDTH/LANE-1:0]  driven,
  output logic                   full,
  output logic                   conflict
);
  localparam int NLANES = WIDTH/LANE;
  localparam int PW     = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t              state_p1, state_nxt;
  logic [PW-1:0]       rr_ptr_p1;
  logic [PW-1:0]       gidx;
  logic [PW-1:0]       cand;
  int unsigned         scan;
  logic                accept;
  logic [LW-1:0]       sel_lane;
  logic [LANE-1:0]     sel_data;
  logic [NLANES-1:0]   driven_p1, driven_nxt;
  logic [WIDTH-1:0]    data_p1;
  logic                conflict_p1;

  // Stage p0: combinational arbitration, scanning from rr_ptr upward
  always_comb begin
    req_ready = '0;
    gidx      = '0;
    cand      = '0;
    scan      = 0;
    accept    = 1'b0;
    if (!rst && !clear && state_p1 != FULL) begin
      for (int i = 0; i < NREQ; i++) begin
        scan = (int'(rr_ptr_p1) + i) % NREQ;
        cand = PW'(scan);
        if (!accept && req_valid[cand]) begin
          accept          = 1'b1;
          req_ready[cand] = 1'b1;
          gidx            = cand;
        end
      end
    end
  end

  assign sel_lane   = req_lane[gidx*LW +: LW];
  assign sel_data   = req_data[gidx*LANE +: LANE];
  assign driven_nxt = driven_p1 | (accept ? (NLANES'(1) << sel_lane) : '0);

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      IDLE:    if (accept) state_nxt = (&driven_nxt) ? FULL : FILL;
      FILL:    if (accept && (&driven_nxt)) state_nxt = FULL;
      FULL:    state_nxt = FULL;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_p1 <= IDLE;
    else     state_p1 <= state_nxt;
  end

  // Stage p1: result register, driven mask, sticky conflict and pointer.
  // A write to an already-driven lane still retires; the first writer keeps the lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1     <= '0;
      driven_p1   <= '0;
      conflict_p1 <= 1'b0;
      rr_ptr_p1   <= '0;
    end else if (clear) begin
      data_p1     <= '0;
      driven_p1   <= '0;
      conflict_p1 <= 1'b0;
    end else if (accept) begin
      rr_ptr_p1 <= (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
      if (driven_p1[sel_lane]) begin
        conflict_p1 <= 1'b1;
      end else begin
        data_p1[sel_lane*LANE +: LANE] <= sel_data;
        driven_p1[sel_lane]            <= 1'b1;
      end
    end
  end

  assign out      = data_p1;
  assign driven   = driven_p1;
  assign full     = (state_p1 == FULL);
  assign conflict = conflict_p1;
endmodule

// File: tb/tb_lane_fill_sched.sv
// Directed self-checking bench for lane_fill_sched: fill, arbitration order,
// conflicts, partial fills, FULL hold/clear and reset during a fill.
module tb_lane_fill_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 128;
  localparam int LANE  = 8;
  localparam int LW    = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*LW-1:0]   req_lane;
  logic [NREQ*LANE-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 clear;
  logic [WIDTH-1:0]     out;
  logic [15:0]          driven;
  logic                 full;
  logic                 conflict;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lane_fill_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LANE(LANE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_lane(req_lane),
    .req_data(req_data), .req_ready(req_ready), .clear(clear), .out(out),
    .driven(driven), .full(full), .conflict(conflict)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input int lane, input logic [7:0] d);
    req_valid[i]             = v;
    req_lane[i*LW +: LW]     = LW'(lane);
    req_data[i*LANE +: LANE] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; req_valid = '0; req_lane = '0; req_data = '0;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (out !== '0) begin n_fail++; $display("FAIL reset_out: got %h expected 0", out); end
    n_checks++; if (driven !== 16'h0) begin n_fail++; $display("FAIL reset_driven: got %h expected 0", driven); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict: got %b expected 0", conflict); end
    req_valid = 4'hF;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_rrptr: ready %b expected 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_fill_single();
    for (int k = 0; k < 16; k++) begin
      drive(0, 1'b1, k, 8'(8'h10 + k));
      #1;
      n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL fill_ready lane %0d: got %b expected 0001", k, req_ready); end
      tick();
      if (k == 14) begin
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL fill_early_full: got %b expected 0", full); end
      end
    end
    req_valid = '0;
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", full); end
    n_checks++; if (driven !== 16'hFFFF) begin n_fail++; $display("FAIL fill_driven: got %h expected ffff", driven); end
    n_checks++; if (out !== 128'h1F1E1D1C1B1A19181716151413121110) begin
      n_fail++; $display("FAIL fill_out: got %h expected 1f1e1d1c1b1a19181716151413121110", out); end
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_round_robin();
    int cnt [NREQ];
    logic [3:0] exp;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++) drive(i, 1'b1, i + 4*cnt[i], 8'(8'h30 + i + 4*cnt[i]));
      #1;
      exp = 4'(1 << (c % 4));
      n_checks++; if (req_ready !== exp) begin n_fail++; $display("FAIL rr_order cycle %0d: got %b expected %b", c, req_ready, exp); end
      n_checks++; if (!$onehot0(req_ready)) begin n_fail++; $display("FAIL rr_onehot cycle %0d: got %b expected at most one bit", c, req_ready); end
      cnt[c % 4]++;
      tick();
    end
    req_valid = '0;
    n_checks++; if (driven !== 16'h00FF) begin n_fail++; $display("FAIL rr_driven: got %h expected 00ff", driven); end
    n_checks++; if (out[63:0] !== 64'h3736353433323130) begin n_fail++; $display("FAIL rr_out: got %h expected 3736353433323130", out[63:0]); end
  endtask

  task automatic test_rst_midfill();
    drive(1, 1'b1, 0, 8'h99);
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_ready: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0;
    n_checks++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL mid_conflict: got %b expected 1", conflict); end
    n_checks++; if (out[7:0] !== 8'h30) begin n_fail++; $display("FAIL mid_first_wins: got %h expected 30", out[7:0]); end
    for (int i = 0; i < NREQ; i++) drive(i, 1'b1, 8 + i, 8'hE0);
    rst = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 0000", req_ready); end
    tick();
    rst = 1'b0;
    n_checks++; if (out !== '0) begin n_fail++; $display("FAIL mid_rst_out: got %h expected 0", out); end
    n_checks++; if (driven !== 16'h0) begin n_fail++; $display("FAIL mid_rst_driven: got %h expected 0", driven); end
    n_checks++; if (full !== 1'b0 || conflict !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags: got full=%b conflict=%b expected 0 0", full, conflict); end
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_rst_rrptr: got %b expected 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_conflict();
    drive(0, 1'b1, 3, 8'hAA);
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL cf_ready0: got %b expected 0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    drive(1, 1'b1, 3, 8'h55);
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL cf_ready1: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0;
    n_checks++; if (out[31:24] !== 8'hAA) begin n_fail++; $display("FAIL cf_out: got %h expected aa", out[31:24]); end
    n_checks++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL cf_flag: got %b expected 1", conflict); end
    n_checks++; if (driven !== 16'h0008) begin n_fail++; $display("FAIL cf_driven: got %h expected 0008", driven); end
    tick();
    n_checks++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL cf_sticky: got %b expected 1", conflict); end
  endtask

  task automatic test_partial();
    clear = 1'b1; tick(); clear = 1'b0;
    n_checks++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL pt_clear_conflict: got %b expected 0", conflict); end
    for (int k = 0; k < 16; k++) begin
      if (k == 2 || k == 3) continue;
      drive(3, 1'b1, k, 8'(8'hC0 + k));
      tick();
    end
    req_valid = '0;
    n_checks++; if (driven !== 16'hFFF3) begin n_fail++; $display("FAIL pt_driven: got %h expected fff3", driven); end
    n_checks++; if (out[31:16] !== 16'h0) begin n_fail++; $display("FAIL pt_gap: got %h expected 0000", out[31:16]); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL pt_full: got %b expected 0", full); end
    n_checks++; if (out[15:0] !== 16'hC1C0 || out[127:32] !== 96'hCFCECDCCCBCAC9C8C7C6C5C4) begin
      n_fail++; $display("FAIL pt_out: got %h expected cfcecdcccbcac9c8c7c6c5c40000c1c0", out); end
  endtask

  task automatic test_full_hold();
    drive(3, 1'b1, 2, 8'hC2); tick();
    drive(3, 1'b1, 2, 8'hEE); tick();
    n_checks++; if (conflict !== 1'b1 || out[23:16] !== 8'hC2) begin
      n_fail++; $display("FAIL fh_conflict: got conflict=%b lane2=%h expected 1 c2", conflict, out[23:16]); end
    drive(3, 1'b1, 3, 8'hC3); tick();
    req_valid = '0;
    n_checks++; if (full !== 1'b1 || driven !== 16'hFFFF) begin
      n_fail++; $display("FAIL fh_full: got full=%b driven=%h expected 1 ffff", full, driven); end
    drive(2, 1'b1, 0, 8'h77);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL fh_ready cycle %0d: got %b expected 0000", c, req_ready); end
      tick();
    end
    n_checks++; if (out[7:0] !== 8'hC0 || out[31:16] !== 16'hC3C2) begin
      n_fail++; $display("FAIL fh_hold: got %h expected c0 / c3c2", out); end
    clear = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL fh_clear_ready: got %b expected 0000", req_ready); end
    tick();
    clear = 1'b0;
    n_checks++; if (out !== '0 || driven !== 16'h0) begin n_fail++; $display("FAIL fh_clear_data: got out=%h driven=%h expected 0 0", out, driven); end
    n_checks++; if (full !== 1'b0 || conflict !== 1'b0) begin n_fail++; $display("FAIL fh_clear_flags: got full=%b conflict=%b expected 0 0", full, conflict); end
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL fh_after_clear: got %b expected 0100", req_ready); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_fill_single();
    test_round_robin();
    test_rst_midfill();
    test_conflict();
    test_partial();
    test_full_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end
endmodule
